// File: rtl/mips_defs.sv
// Shared execute-stage definitions for the divider.
// Contents: divider FSM state encoding, divider width/iteration count,
// and the ALU control codes for DIV/DIVU. Execute-stage decode uses
// these codes to derive start_i/signed_i from alucontrolE.
package mips_defs;
  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam logic [4:0] ALU_DIV  = 5'b10000;
  localparam logic [4:0] ALU_DIVU = 5'b10001;

  function automatic logic is_div_op(input logic [4:0] alucontrol);
    return (alucontrol == ALU_DIV) || (alucontrol == ALU_DIVU);
  endfunction

  function automatic logic is_signed_div(input logic [4:0] alucontrol);
    return alucontrol == ALU_DIV;
  endfunction
endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider bundle.
// master: execute stage / hazard side (drives request, sees stall/result)
// slave : div_unit
//   start_i  divide request     signed_i  1=DIV, 0=DIVU
//   opa_i    dividend           opb_i     divisor
//   annul_i  cancel (flushE)    stall_o   stall request to hazard unit
//   ready_o  one-cycle result valid pulse
//   result_o {remainder, quotient} for HI/LO
interface div_unit_if
  import mips_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opa_i;
  logic [WIDTH-1:0]   opb_i;
  logic               annul_i;
  logic               stall_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (output start_i, signed_i, opa_i, opb_i, annul_i,
                  input  stall_o, ready_o, result_o);
  modport slave  (input  start_i, signed_i, opa_i, opb_i, annul_i,
                  output stall_o, ready_o, result_o);
endinterface

// File: rtl/div_step.sv
// One combinational radix-2 restoring division iteration.
// Ports: rem (WIDTH+1 partial remainder), quo (shifting dividend/quotient),
//        divisor, rem_n / quo_n (values after this iteration).
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // Extra top bit makes the borrow explicit even for a zero divisor.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {2'b00, divisor};
  assign borrow  = diff[WIDTH+1];
  assign rem_n   = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
  assign quo_n   = {quo[WIDTH-2:0], ~borrow};
endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the execute stage.
// Ports: clk, rst (synchronous, active-high), bus (div_unit_if.slave):
//   request start_i/signed_i/opa_i/opb_i, cancel annul_i,
//   stall_o to hazard unit, ready_o pulse with result_o = {rem, quo}.
// Optional: define DIV_ZERO_FAST_EN to finish a divide-by-zero in one
// cycle instead of iterating; the result is identical either way.
module div_unit
  import mips_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  div_state_t         state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo, divisor;
  logic               quo_neg, rem_neg;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH:0]     rem_n;
  logic [WIDTH-1:0]   quo_n;

  logic               sa, sb, accept, last_step, fast_zero;
  logic [WIDTH-1:0]   opa_abs, opb_abs;

  assign sa        = bus.signed_i & bus.opa_i[WIDTH-1];
  assign sb        = bus.signed_i & bus.opb_i[WIDTH-1];
  assign opa_abs   = sa ? (~bus.opa_i + 1'b1) : bus.opa_i;
  assign opb_abs   = sb ? (~bus.opb_i + 1'b1) : bus.opb_i;
  assign accept    = (state == DIV_IDLE) & bus.start_i & ~bus.annul_i;
  assign last_step = (cnt == CNT_W'(WIDTH-1));

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = (bus.opb_i == '0);
`else
  assign fast_zero = 1'b0;
`endif

  function automatic logic [2*WIDTH-1:0] fix_sign(
    input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] q,
    input logic rn, input logic qn);
    logic [WIDTH-1:0] rf, qf;
    rf = rn ? (~r + 1'b1) : r;
    qf = qn ? (~q + 1'b1) : q;
    return {rf, qf};
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem    (rem),
    .quo    (quo),
    .divisor(divisor),
    .rem_n  (rem_n),
    .quo_n  (quo_n)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_n;
  end

  // Next-state logic; annul_i outranks start_i in every state
  always_comb begin
    state_n = state;
    unique case (state)
      DIV_IDLE: if (accept) state_n = fast_zero ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (bus.annul_i)  state_n = DIV_IDLE;
                else if (last_step) state_n = DIV_DONE;
      DIV_DONE: state_n = DIV_IDLE;
      default:  state_n = DIV_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.stall_o = 1'b0;
    bus.ready_o = 1'b0;
    unique case (state)
      DIV_IDLE: bus.stall_o = accept;
      DIV_BUSY: bus.stall_o = ~bus.annul_i;
      DIV_DONE: bus.ready_o = 1'b1;
      default:  ;
    endcase
  end

  assign bus.result_o = result;

  // Datapath; result is captured on entry to DONE and held afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      quo_neg <= 1'b0;
      rem_neg <= 1'b0;
      result  <= '0;
    end else if (accept) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= opa_abs;
      divisor <= opb_abs;
      quo_neg <= sa ^ sb;
      rem_neg <= sa;
      // Raw divide-by-zero result is {|opa|, all ones}
      if (fast_zero) result <= fix_sign(opa_abs, '1, sa, sa ^ sb);
    end else if ((state == DIV_BUSY) && !bus.annul_i) begin
      cnt <= cnt + 1'b1;
      rem <= rem_n;
      quo <= quo_n;
      if (last_step) result <= fix_sign(rem_n[WIDTH-1:0], quo_n, rem_neg, quo_neg);
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors feed a scoreboard
// queue; a negedge monitor pops and checks result and latency on ready_o.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus();
  div_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  typedef struct { logic [63:0] res; int t0; int lat; } exp_t;
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready_o must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.ready_o === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result %h expected no ready (cycle %0d)",
                 bus.result_o, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", bus.result_o, e.res);
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single cycle; leaves time at cycle t0+1
  task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input int lat, input bit expect_it);
    bus.start_i  = 1'b1;
    bus.signed_i = sg;
    bus.opa_i    = a;
    bus.opb_i    = b;
    if (expect_it) sbq.push_back('{res, cyc, lat});
    step();
    bus.start_i = 1'b0;
  endtask

  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input int lat);
    issue(sg, a, b, res, lat, 1'b1);
    repeat (lat) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.annul_i = 1'b0;
    bus.opa_i = '0; bus.opb_i = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall",  64'(bus.stall_o), 64'd0);
    chk("reset_ready",  64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    step();

    // DIVU 100/7 with per-cycle stall profile
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opa_i = 32'd100; bus.opb_i = 32'd7;
    sbq.push_back('{{32'd2, 32'd14}, cyc, 33});
    for (int i = 0; i <= 33; i++) begin
      @(negedge clk);
      chk($sformatf("stall_c%0d", i), 64'(bus.stall_o), (i <= 32) ? 64'd1 : 64'd0);
      step();
      if (i == 0) bus.start_i = 1'b0;
    end
    @(negedge clk);
    chk("result_hold", bus.result_o, {32'd2, 32'd14});
    step();

    // Signed cases
    run_div(1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_div(1'b1, 32'd7,        32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD}, 33);
    run_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14},       33);
    // Signed overflow, then an immediate back-to-back DIVU
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0,        32'h80000000}, 33);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1,        {32'h0,        32'hFFFFFFFF}, 33);

    // Divide by zero
    issue(1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFFFFFF}, ZLAT, 1'b1);
    @(negedge clk);
    chk("zero_stall_c1", 64'(bus.stall_o), (ZLAT == 1) ? 64'd0 : 64'd1);
    repeat (ZLAT) step();

    // Annul in BUSY cycle 10; restart in cycle 12 completes 33 cycles later
    issue(1'b0, 32'd100, 32'd7, '0, 0, 1'b0);
    repeat (9) step();
    bus.annul_i = 1'b1;
    @(negedge clk);
    chk("annul_stall", 64'(bus.stall_o), 64'd0);
    step();
    bus.annul_i = 1'b0;
    step();
    run_div(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);

    // Reset in BUSY cycle 5
    issue(1'b0, 32'd55, 32'd5, '0, 0, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall",  64'(bus.stall_o), 64'd0);
    chk("rst_ready",  64'(bus.ready_o), 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    step();

    // start_i held high through DONE must not restart
    bus.start_i = 1'b1; bus.signed_i = 1'b1; bus.opa_i = 32'hFFFFFFF9; bus.opb_i = 32'd2;
    sbq.push_back('{{32'hFFFFFFFF, 32'hFFFFFFFD}, cyc, 33});
    repeat (33) step();
    @(negedge clk);
    chk("done_stall", 64'(bus.stall_o), 64'd0);
    step();
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("idle_after_held_stall", 64'(bus.stall_o), 64'd0);
    repeat (40) step();

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL missing_ready: got %0d outstanding expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
